// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 width codes, error codes
// and the FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, write replication, load extraction
// with sign/zero extension, and the misalign/illegal-funct3 checks.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        illegal
);

    logic [1:0]  size;
    logic [31:0] lane;

    assign size = funct3[1:0];
    assign lane = rdata >> {offset, 3'b000};

    always_comb begin
        be = 4'b1111;
        case (size)
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
    end

    // Every byte lane carries the datum that belongs there whatever the offset.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign wdata[8*gi +: 8] = (size == 2'b00) ? store_data[7:0] :
                                  (size == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                                    store_data[8*gi +: 8];
    end

    always_comb begin
        load_data = lane;
        case (funct3)
            F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   load_data = {24'd0, lane[7:0]};
            F3_HU:   load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    assign illegal  = is_store ? (funct3 > F3_W)
                               : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    assign misalign = ((size == 2'b01) && offset[0]) ||
                      ((size == 2'b10) && (offset != 2'b00));

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one byte/half/word access per request on a
// ready/valid data bus, with misalign, illegal and timeout reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  err_code
);

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic        is_store_q, is_store_d;
    logic [31:0] sdata_q, sdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic [1:0]  err_q, err_d;

    logic        in_idle, in_access, accept;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr, sel_sdata;
    logic        sel_store;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;
    logic        al_misalign, al_illegal;

    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);
    assign accept    = in_idle && start && (is_load ^ is_store);

    // In IDLE the checks look at the incoming request; afterwards at the latched one.
    assign sel_f3    = in_idle ? funct3     : f3_q;
    assign sel_addr  = in_idle ? addr       : addr_q;
    assign sel_store = in_idle ? is_store   : is_store_q;
    assign sel_sdata = in_idle ? store_data : sdata_q;

    lsu_align u_align (
        .funct3     (sel_f3),
        .offset     (sel_addr[1:0]),
        .is_store   (sel_store),
        .store_data (sel_sdata),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misalign   (al_misalign),
        .illegal    (al_illegal)
    );

    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        is_store_d  = is_store_q;
        sdata_d     = sdata_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    f3_d       = funct3;
                    addr_d     = addr;
                    is_store_d = is_store;
                    sdata_d    = store_data;
                    cnt_d      = 8'd0;
                    if (al_illegal) begin
                        state_d     = ST_DONE;
                        err_d       = ERR_ILLEGAL;
                        load_data_d = 32'd0;
                    end else if (al_misalign) begin
                        state_d     = ST_DONE;
                        err_d       = ERR_MISALIGN;
                        load_data_d = 32'd0;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_d     = ST_DONE;
                    err_d       = ERR_NONE;
                    load_data_d = is_store_q ? 32'd0 : al_load;
                    cnt_d       = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_L) begin
                        state_d     = ST_DONE;
                        err_d       = ERR_TIMEOUT;
                        load_data_d = 32'd0;
                        cnt_d       = 8'd0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            f3_q        <= 3'd0;
            addr_q      <= 32'd0;
            is_store_q  <= 1'b0;
            sdata_q     <= 32'd0;
            cnt_q       <= 8'd0;
            load_data_q <= 32'd0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            is_store_q  <= is_store_d;
            sdata_q     <= sdata_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    // Bus outputs are zero outside ACCESS so the port is quiet when idle.
    assign mem_req   = in_access;
    assign mem_we    = in_access && is_store_q;
    assign mem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be    = in_access ? al_be : 4'd0;
    assign mem_wdata = in_access ? al_wdata : 32'd0;
    assign busy      = !in_idle;
    assign done      = (state_q == ST_DONE);
    assign load_data = load_data_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a few hand-written sequences
// for timeout, start-while-busy and reset-during-access.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy, done;
    logic [31:0] load_data;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .load_data(load_data), .err_code(err_code)
    );

    typedef struct {
        logic        st;       // 1 = store, 0 = load
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          waits;
        logic        exp_acc;  // bus access expected
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd);
        @(negedge clk);
        start = 1'b1; is_load = !st; is_store = st;
        funct3 = f3; addr = a; store_data = sd;
        @(posedge clk); #1;
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        string nm;
        v = vecs[idx];
        nm = $sformatf("v%0d", idx);
        issue(v.st, v.f3, v.a, v.sd);
        if (v.exp_acc) begin
            for (int c = 0; c <= v.waits; c++) begin
                mem_ready = (c == v.waits);
                mem_rdata = (c == v.waits) ? v.rd : 32'h5555_AAAA;
                #1;
                chk({nm, "_req"}, 32'(mem_req), 32'd1);
                chk({nm, "_done_early"}, 32'(done), 32'd0);
                chk({nm, "_addr"}, mem_addr, v.exp_addr);
                chk({nm, "_be"}, 32'(mem_be), 32'(v.exp_be));
                chk({nm, "_we"}, 32'(mem_we), 32'(v.st));
                if (v.st) chk({nm, "_wdata"}, mem_wdata, v.exp_wdata);
                @(posedge clk); #1;
            end
            mem_ready = 1'b0;
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_req_off"}, 32'(mem_req), 32'd0);
        chk({nm, "_err"}, 32'(err_code), 32'(v.exp_err));
        chk({nm, "_load"}, load_data, v.exp_load);
        @(posedge clk); #1;
        chk({nm, "_idle"}, 32'(busy), 32'd0);
        chk({nm, "_hold"}, load_data, v.exp_load);
        $display("[TB] txn %s st=%0b f3=%03b addr=0x%08h load=0x%08h err=%0d",
                 nm, v.st, v.f3, v.a, load_data, err_code);
    endtask

    initial begin
        //          st    f3      addr           sdata          rdata          w  acc  exp_addr       be       wdata          load           err
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 0, 1'b1, 32'h0000_1004, 4'b1111, 32'h0,         32'hDEAD_BEEF, 2'd0};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_2003, 32'h0,         32'h8012_3456, 0, 1'b1, 32'h0000_2000, 4'b1000, 32'h0,         32'hFFFF_FF80, 2'd0};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_2003, 32'h0,         32'h8012_3456, 0, 1'b1, 32'h0000_2000, 4'b1000, 32'h0,         32'h0000_0080, 2'd0};
        vecs[3]  = '{1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h0,         3, 1'b1, 32'h0000_3000, 4'b1100, 32'hABCD_ABCD, 32'h0,         2'd0};
        vecs[4]  = '{1'b0, 3'b001, 32'h0000_0001, 32'h0,         32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         2'd1};
        vecs[5]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         2'd1};
        vecs[6]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         2'd3};
        vecs[7]  = '{1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h0,         1, 1'b1, 32'h0000_0010, 4'b0010, 32'hA5A5_A5A5, 32'h0,         2'd0};
        vecs[8]  = '{1'b0, 3'b101, 32'h0000_4002, 32'h0,         32'h9ABC_1234, 0, 1'b1, 32'h0000_4000, 4'b1100, 32'h0,         32'h0000_9ABC, 2'd0};
        vecs[9]  = '{1'b0, 3'b001, 32'h0000_4002, 32'h0,         32'h9ABC_1234, 1, 1'b1, 32'h0000_4000, 4'b1100, 32'h0,         32'hFFFF_9ABC, 2'd0};
        vecs[10] = '{1'b1, 3'b100, 32'h0000_0000, 32'h1111_1111, 32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         2'd3};
        vecs[11] = '{1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,         2, 1'b1, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0,         2'd0};

        rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i);

        // start with neither / both operation flags is ignored
        @(negedge clk);
        start = 1'b1; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(posedge clk); #1;
        chk("neither_busy", 32'(busy), 32'd0);
        is_load = 1'b1; is_store = 1'b1;
        @(posedge clk); #1;
        chk("both_busy", 32'(busy), 32'd0);
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        $display("[TB] txn start-without-single-op ignored");

        // timeout with a start pulse while busy and another during DONE
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        for (int c = 0; c < 4; c++) begin
            start = (c == 1); is_load = (c == 1);
            #1;
            chk($sformatf("to_req%0d", c), 32'(mem_req), 32'd1);
            chk($sformatf("to_addr%0d", c), mem_addr, 32'h0000_0100);
            @(posedge clk); #1;
            start = 1'b0; is_load = 1'b0;
        end
        chk("to_done", 32'(done), 32'd1);
        chk("to_err", 32'(err_code), 32'd2);
        chk("to_req_off", 32'(mem_req), 32'd0);
        chk("to_load", load_data, 32'd0);
        start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h0;
        @(posedge clk); #1;
        start = 1'b0; is_load = 1'b0;
        chk("to_done_start_busy", 32'(busy), 32'd0);
        chk("to_done_off", 32'(done), 32'd0);
        $display("[TB] txn timeout err=%0d", err_code);

        // reset during the second ACCESS cycle abandons the access
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
        chk("rsta_req1", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        chk("rsta_req2", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rsta_req", 32'(mem_req), 32'd0);
        chk("rsta_addr", mem_addr, 32'd0);
        chk("rsta_be", 32'(mem_be), 32'd0);
        chk("rsta_busy", 32'(busy), 32'd0);
        chk("rsta_done", 32'(done), 32'd0);
        chk("rsta_err", 32'(err_code), 32'd0);
        @(posedge clk); #1;
        chk("rsta_no_done", 32'(done), 32'd0);
        $display("[TB] txn reset-during-access");
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
